// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit layout and region decode for the data-side responder.
package dmem_pkg;

    localparam logic [31:0] ADDR_TIMER   = 32'h8000_0000;
    localparam logic [31:0] ADDR_TIMECMP = 32'h8000_0004;
    localparam logic [31:0] ADDR_STATUS  = 32'h8000_0008;
    localparam logic [31:0] ADDR_TOHOST  = 32'h8000_000C;
    localparam logic [3:0]  RAM_NIBBLE   = 4'h0;

    localparam int unsigned STAT_IRQ = 0;
    localparam int unsigned STAT_ERR = 1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TIMER,
        REG_TIMECMP,
        REG_STATUS,
        REG_TOHOST,
        REG_NONE
    } region_t;

    // Decodes on the word-aligned address so misaligned reads land on the aligned word.
    function automatic region_t decodeRegion(logic [31:0] adr);
        logic [31:0] wordAdr;
        region_t     region;
        wordAdr = {adr[31:2], 2'b00};
        if (adr[31:28] == RAM_NIBBLE) begin
            region = REG_RAM;
        end else begin
            unique case (wordAdr)
                ADDR_TIMER:   region = REG_TIMER;
                ADDR_TIMECMP: region = REG_TIMECMP;
                ADDR_STATUS:  region = REG_STATUS;
                ADDR_TOHOST:  region = REG_TOHOST;
                default:      region = REG_NONE;
            endcase
        end
        return region;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with a compare register and a sticky compare interrupt.
module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        timerWe,
    input  logic        timecmpWe,
    input  logic        irqClr,
    input  logic [31:0] wrData,
    output logic [31:0] counter,
    output logic [31:0] timecmp,
    output logic        irq
);

    logic [31:0] counterQ, counterD;
    logic [31:0] timecmpQ, timecmpD;
    logic        irqQ, irqD;

    always_comb begin
        counterD = timerWe ? wrData : counterQ + 32'd1;
        timecmpD = timecmpWe ? wrData : timecmpQ;
        // Compare uses pre-edge values; a pending set beats a same-cycle clear.
        if (counterQ == timecmpQ) begin
            irqD = 1'b1;
        end else if (irqClr) begin
            irqD = 1'b0;
        end else begin
            irqD = irqQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counterQ <= 32'd0;
            timecmpQ <= 32'hFFFF_FFFF;
            irqQ     <= 1'b0;
        end else begin
            counterQ <= counterD;
            timecmpQ <= timecmpD;
            irqQ     <= irqD;
        end
    end

    assign counter = counterQ;
    assign timecmp = timecmpQ;
    assign irq     = irqQ;

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus timer, STATUS and tohost registers, combinational reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        timer_irq,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        bus_err
);

    localparam int unsigned AddrW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];

    region_t         region;
    logic            misaligned;
    logic            validWr;
    logic            ramWe, timerWe, timecmpWe, statusWe, tohostWe;
    logic            errSet, errClr, irqClr;
    logic [AddrW-1:0] ramIdx;
    logic [31:0]     counter, timecmp, statusWord;
    logic            irq;
    logic            errQ, errD;
    logic            tohostValidQ;
    logic [31:0]     tohostDataQ;

    assign region     = decodeRegion(DataAdr);
    assign misaligned = |DataAdr[1:0];
    assign ramIdx     = DataAdr[AddrW+1:2];

    // Misaligned writes are dropped in every region and only flag an error.
    assign validWr   = MemWrite && !misaligned;
    assign ramWe     = validWr && (region == REG_RAM);
    assign timerWe   = validWr && (region == REG_TIMER);
    assign timecmpWe = validWr && (region == REG_TIMECMP);
    assign statusWe  = validWr && (region == REG_STATUS);
    assign tohostWe  = validWr && (region == REG_TOHOST);
    assign errSet    = MemWrite && (misaligned || (region == REG_NONE));
    assign irqClr    = statusWe && WriteData[STAT_IRQ];
    assign errClr    = statusWe && WriteData[STAT_ERR];

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .timerWe   (timerWe),
        .timecmpWe (timecmpWe),
        .irqClr    (irqClr),
        .wrData    (WriteData),
        .counter   (counter),
        .timecmp   (timecmp),
        .irq       (irq)
    );

    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramIdx] <= WriteData;
        end
    end

    always_comb begin
        errD = errQ;
        if (errSet) begin
            errD = 1'b1;
        end else if (errClr) begin
            errD = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errQ         <= 1'b0;
            tohostValidQ <= 1'b0;
            tohostDataQ  <= 32'd0;
        end else begin
            errQ <= errD;
            if (tohostWe) begin
                tohostValidQ <= 1'b1;
                tohostDataQ  <= WriteData;
            end
        end
    end

    always_comb begin
        statusWord           = 32'd0;
        statusWord[STAT_IRQ] = irq;
        statusWord[STAT_ERR] = errQ;
    end

    always_comb begin
        ReadData = 32'd0;
        unique case (region)
            REG_RAM:     ReadData = ram[ramIdx];
            REG_TIMER:   ReadData = counter;
            REG_TIMECMP: ReadData = timecmp;
            REG_STATUS:  ReadData = statusWord;
            REG_TOHOST:  ReadData = tohostDataQ;
            default:     ReadData = 32'd0;
        endcase
    end

    assign timer_irq    = irq;
    assign bus_err      = errQ;
    assign tohost_valid = tohostValidQ;
    assign tohost_data  = tohostDataQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, timer/compare, STATUS W1C, tohost and async reset.
module tb_dmem_responder;

    localparam logic [31:0] A_TIMER   = 32'h8000_0000;
    localparam logic [31:0] A_TIMECMP = 32'h8000_0004;
    localparam logic [31:0] A_STATUS  = 32'h8000_0008;
    localparam logic [31:0] A_TOHOST  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        timer_irq;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .RAM_WORDS (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .timer_irq    (timer_irq),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .bus_err      (bus_err)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rdCheck(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = adr;
        #1;
        checkEq(tag, ReadData, exp);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;

        // Reset state; counter is held at 0 while reset is asserted.
        tick();
        tick();
        checkEq("rst_irq", {31'd0, timer_irq}, 32'd0);
        checkEq("rst_valid", {31'd0, tohost_valid}, 32'd0);
        checkEq("rst_tohost", tohost_data, 32'd0);
        checkEq("rst_err", {31'd0, bus_err}, 32'd0);
        rdCheck("rst_timer", A_TIMER, 32'd0);
        rdCheck("rst_timecmp", A_TIMECMP, 32'hFFFF_FFFF);
        rdCheck("rst_status", A_STATUS, 32'd0);
        reset = 1'b0;

        // Compare: counter 0 -> 1 on this edge while TIMECMP loads 3.
        doWrite(A_TIMECMP, 32'd3);
        checkEq("cmp_irq_c1", {31'd0, timer_irq}, 32'd0);
        rdCheck("cmp_cnt_1", A_TIMER, 32'd1);
        tick();
        checkEq("cmp_irq_c2", {31'd0, timer_irq}, 32'd0);
        tick();
        checkEq("cmp_irq_c3", {31'd0, timer_irq}, 32'd0);
        rdCheck("cmp_cnt_3", A_TIMER, 32'd3);
        tick();
        checkEq("cmp_irq_set", {31'd0, timer_irq}, 32'd1);
        rdCheck("cmp_status", A_STATUS, 32'd1);
        doWrite(A_STATUS, 32'd1);
        checkEq("irq_w1c", {31'd0, timer_irq}, 32'd0);

        // RAM write/read, aliasing, misaligned read, no write-through.
        doWrite(32'h0000_0010, 32'hDEAD_BEEF);
        rdCheck("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rdCheck("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
        rdCheck("ram_misal_rd", 32'h0000_0012, 32'hDEAD_BEEF);
        doWrite(32'h0000_0014, 32'h1111_1111);
        MemWrite  = 1'b1;
        DataAdr   = 32'h0000_0014;
        WriteData = 32'h2222_2222;
        #1;
        checkEq("ram_rd_during_wr", ReadData, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        rdCheck("ram_rd_after_wr", 32'h0000_0014, 32'h2222_2222);

        // Timer load wins over increment, then resumes.
        doWrite(A_TIMER, 32'h0000_0100);
        rdCheck("timer_load", A_TIMER, 32'h0000_0100);
        tick();
        rdCheck("timer_inc", A_TIMER, 32'h0000_0101);

        // Error paths and STATUS err W1C.
        doWrite(32'h0000_0013, 32'h1234_5678);
        rdCheck("misal_wr_ignored", 32'h0000_0010, 32'hDEAD_BEEF);
        checkEq("misal_err", {31'd0, bus_err}, 32'd1);
        doWrite(32'h4000_0000, 32'd5);
        rdCheck("unmapped_rd", 32'h4000_0000, 32'd0);
        rdCheck("unmapped_mmio_rd", 32'h8000_0010, 32'd0);
        checkEq("unmapped_err", {31'd0, bus_err}, 32'd1);
        rdCheck("status_err", A_STATUS, 32'd2);
        doWrite(A_STATUS, 32'd2);
        checkEq("err_w1c", {31'd0, bus_err}, 32'd0);

        // Tohost, then async reset mid-cycle.
        doWrite(32'h4000_0004, 32'd0);
        doWrite(A_TOHOST, 32'd1);
        checkEq("tohost_valid", {31'd0, tohost_valid}, 32'd1);
        checkEq("tohost_data", tohost_data, 32'd1);
        rdCheck("tohost_rd", A_TOHOST, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkEq("arst_valid", {31'd0, tohost_valid}, 32'd0);
        checkEq("arst_data", tohost_data, 32'd0);
        checkEq("arst_err", {31'd0, bus_err}, 32'd0);
        rdCheck("arst_timer", A_TIMER, 32'd0);
        rdCheck("arst_status", A_STATUS, 32'd0);
        rdCheck("arst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        tick();
        rdCheck("arst_timer_held", A_TIMER, 32'd0);
        tick();
        reset = 1'b0;

        // Wrap: FFFF_FFFF -> 0, irq one edge after counter equals TIMECMP=0.
        doWrite(A_TIMECMP, 32'd0);
        doWrite(A_TIMER, 32'hFFFF_FFFF);
        rdCheck("wrap_pre", A_TIMER, 32'hFFFF_FFFF);
        tick();
        rdCheck("wrap_zero", A_TIMER, 32'd0);
        checkEq("wrap_irq0", {31'd0, timer_irq}, 32'd0);
        tick();
        checkEq("wrap_irq1", {31'd0, timer_irq}, 32'd1);
        rdCheck("wrap_cnt1", A_TIMER, 32'd1);

        // Set beats same-cycle W1C of irq.
        doWrite(A_TIMECMP, 32'd3);
        doWrite(A_STATUS, 32'd1);
        checkEq("w1c_plain", {31'd0, timer_irq}, 32'd0);
        doWrite(A_STATUS, 32'd1);
        checkEq("set_beats_clr", {31'd0, timer_irq}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
